alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
- Issue stage directly upstream of the MIPS `alu` block.
- Accepts a 32-bit instruction stream and reads rs/rt from an internal 32x32 GPR file.
- Presents instruction/regA/regB to the ALU through a registered valid/ready output.
- Retires ALU result/flags back into the GPR file, with an in-order scoreboard preventing RAW/WAW hazards. Branch outcome for beq/bne is resolved at retire.

Parameters:
- DEPTH, 4, max instructions issued but not yet retired (power of 2, 2..16).
- ADDR_W, 2, log2(DEPTH).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction available.
- in_instr  in  32  MIPS instruction.
- in_ready  out  1  stage accepts in_instr this cycle.
- out_valid  out  1  ALU operands valid.
- out_ready  in  1  ALU/downstream consumes operands.
- out_instr  out  32  to alu instruction.
- out_regA  out  32  GPR[rs].
- out_regB  out  32  GPR[rt].
- wb_valid  in  1  ALU result for oldest in-flight instruction.
- wb_result  in  32  ALU result (or load data for lw).
- wb_flags  in  3  {zero, negative, overflow}, matching the alu flags port bit order [2:0].
- branch_taken  out  1  one-cycle pulse on beq/bne retire when taken.
- wb_err  out  1  sticky: wb_valid seen with scoreboard empty.
- dbg_addr  in  5  debug GPR read address.
- dbg_data  out  32  combinational GPR[dbg_addr], 0 for addr 0.

Behaviour:
- Reset: all GPRs 0, scoreboard empty, pending bits 0, out_valid/out_instr/out_regA/out_regB 0, branch_taken 0, wb_err 0.
- Decode of destination:
  - R-type (op 000000): rd.
  - addi/addiu/slti/sltiu/andi/ori/xori/lw: rt.
  - sw/beq/bne/unknown: none.
  - Destination 0 is treated as none.
- Hazard: stall = (rs!=0 && pending[rs]) || (rt!=0 && pending[rt]) || (dest!=none && pending[dest]).
  - Pending bits are sampled at cycle start; there is no writeback bypass, so a dependent instruction issues one cycle after retire at the earliest.
- in_ready = !stall && count<DEPTH && (!out_valid || out_ready).
  - Evaluated combinationally; in_valid must not feed back into in_ready.
- Accept (in_valid && in_ready):
  - Next edge loads out_instr/out_regA/out_regB from the GPR file and sets out_valid=1.
  - Pushes the scoreboard entry {dest, has_dest, trap_ovf, is_beq, is_bne}.
  - Sets pending[dest] when has_dest.
  - Latency from accept to out_valid: 1 cycle.
- trap_ovf=1 for add (funct 100000), sub (100010), addi (op 001000).
- Output hold: while out_valid && !out_ready, the out_* registers are stable. out_valid clears on a consume edge unless a new accept occurs in the same cycle.
- Retire (wb_valid with count>0): pops the head entry.
  - If has_dest && !(trap_ovf && wb_flags[0]), GPR[dest] <= wb_result.
  - pending[dest] is cleared regardless of whether the write was suppressed.
  - branch_taken pulses next cycle if (is_beq && wb_flags[2]) || (is_bne && !wb_flags[2]).
- Retire with count==0: ignored; wb_err set until reset.
- Simultaneous accept and retire: count unchanged, both pointers advance.
  - Full (count==DEPTH) blocks accept even if wb_valid is high that cycle.
- The same register retiring and being newly claimed in one cycle cannot occur, because the WAW stall prevents it.
- Pointers wrap modulo DEPTH.
- GPR[0] reads 0 and is never written.
- Reset asserted mid-operation: the scoreboard is discarded and in-flight results are lost.

Decomposition:
- Shared package mips_pkg:
  - opcode/funct constants (OP_RTYPE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LW, OP_SW, OP_BEQ, OP_BNE, FN_ADD, FN_SUB, ...).
  - Flag bit indices FLAG_ZERO=2, FLAG_NEG=1, FLAG_OVF=0.
  - Field-slice helpers for rs/rt/rd.
- One sub-module: alu_scoreboard_fifo, holding the DEPTH-entry in-order FIFO, count, and pending bit vector.
- The GPR file and decode stay in the top.

Test Plan:
- Reset then issue `addiu $1,$0,5` (0x24010005):
  - out_valid next cycle with regA=0, regB=0.
  - Retire wb_result=5, flags=000 → dbg GPR[1]=5.
- Back-to-back dependency: `addu $3,$1,$1` after the $1 writer.
  - in_ready=0 until the $1 retire, then issues one cycle later with regA=regB=5.
  - Retire 10 → GPR[3]=0x0000000A.
- Overflow suppression: add to $3.
  - Retire wb_result=0x00000002, flags=001 → GPR[3] unchanged, pending[3] cleared.
  - The same value with addu writes 2.
- Branch: beq retire flags=100 → branch_taken pulse 1 cycle.
  - bne retire flags=100 → no pulse.
  - bne retire flags=000 → pulse.
- Full/backpressure: hold out_ready=0 and issue independent instructions to $1..$4 (DEPTH=4).
  - out_* stable; in_ready=0 after the 4th accept.
  - One wb_valid with a simultaneous in_valid does not accept that cycle; the next cycle does.
- Stray wb_valid with the scoreboard empty → wb_err=1 and no GPR change. Asserting rst_n=0 clears wb_err asynchronously.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS opcode/funct constants, flag bit positions and instruction field helpers
// used by the operand stage and its scoreboard.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;

  localparam int FLAG_ZERO = 2;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_OVF  = 0;

  typedef struct packed {
    logic [4:0] dest;
    logic       has_dest;
    logic       trap_ovf;
    logic       is_beq;
    logic       is_bne;
  } sb_entry_t;

  function automatic logic [5:0] get_op(input logic [31:0] instr);
    return instr[31:26];
  endfunction

  function automatic logic [4:0] get_rs(input logic [31:0] instr);
    return instr[25:21];
  endfunction

  function automatic logic [4:0] get_rt(input logic [31:0] instr);
    return instr[20:16];
  endfunction

  function automatic logic [4:0] get_rd(input logic [31:0] instr);
    return instr[15:11];
  endfunction

  function automatic logic [5:0] get_funct(input logic [31:0] instr);
    return instr[5:0];
  endfunction

endpackage

// File: rtl/alu_scoreboard_fifo.sv
// In-order scoreboard: DEPTH-entry FIFO of issued-but-unretired instructions,
// occupancy count, and per-GPR pending bits.
module alu_scoreboard_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  sb_entry_t       push_entry,
  input  logic            pop,
  output sb_entry_t       head_entry,
  output logic [ADDR_W:0] count,
  output logic            full,
  output logic            empty,
  output logic [31:0]     pending
);

  sb_entry_t         mem_reg [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W:0]   count_reg;
  logic [ADDR_W:0]   count_next;
  logic [31:0]       pending_reg;
  logic [31:0]       pending_next;

  assign head_entry = mem_reg[rd_ptr_reg];
  assign count      = count_reg;
  assign full       = (count_reg == (ADDR_W + 1)'(DEPTH));
  assign empty      = (count_reg == '0);
  assign pending    = pending_reg;

  always_comb begin
    count_next   = count_reg;
    pending_next = pending_reg;
    if (push && !pop) count_next = count_reg + 1'b1;
    if (pop && !push) count_next = count_reg - 1'b1;
    // Clear before set: the WAW stall keeps the two from ever naming the same register.
    if (pop && head_entry.has_dest) pending_next[head_entry.dest] = 1'b0;
    if (push && push_entry.has_dest) pending_next[push_entry.dest] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_reg[wr_ptr_reg] <= push_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      pending_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg   <= count_next;
      pending_reg <= pending_next;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Issue stage in front of the MIPS alu: GPR file, destination decode, hazard stall,
// registered operand output and in-order retire with overflow trap and branch resolve.
module alu_operand_stage
  import mips_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_regA,
  output logic [31:0] out_regB,
  input  logic        wb_valid,
  input  logic [31:0] wb_result,
  input  logic [2:0]  wb_flags,
  output logic        branch_taken,
  output logic        wb_err,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  logic [31:0] gpr_reg [32];
  logic [31:0] gpr_we;
  logic        out_valid_reg;
  logic [31:0] out_instr_reg;
  logic [31:0] out_rega_reg;
  logic [31:0] out_regb_reg;
  logic        branch_taken_reg;
  logic        wb_err_reg;

  sb_entry_t       dec_entry;
  sb_entry_t       head_entry;
  logic [ADDR_W:0] sb_count;
  logic            sb_full;
  logic            sb_empty;
  logic [31:0]     pending;
  logic [4:0]      rs;
  logic [4:0]      rt;
  logic            stall;
  logic            accept;
  logic            retire;
  logic            wr_en;

  assign rs = get_rs(in_instr);
  assign rt = get_rt(in_instr);

  always_comb begin
    dec_entry = '0;
    unique case (get_op(in_instr))
      OP_RTYPE: begin
        dec_entry.dest     = get_rd(in_instr);
        dec_entry.has_dest = 1'b1;
        dec_entry.trap_ovf = (get_funct(in_instr) == FN_ADD) || (get_funct(in_instr) == FN_SUB);
      end
      OP_ADDI: begin
        dec_entry.dest     = rt;
        dec_entry.has_dest = 1'b1;
        dec_entry.trap_ovf = 1'b1;
      end
      OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LW: begin
        dec_entry.dest     = rt;
        dec_entry.has_dest = 1'b1;
      end
      OP_BEQ:  dec_entry.is_beq = 1'b1;
      OP_BNE:  dec_entry.is_bne = 1'b1;
      default: dec_entry = '0;
    endcase
    // Writes to $0 are discarded, so they never claim a pending bit.
    if (dec_entry.dest == 5'd0) dec_entry.has_dest = 1'b0;
    if (!dec_entry.has_dest)    dec_entry.dest     = 5'd0;
  end

  assign stall = ((rs != 5'd0) && pending[rs]) ||
                 ((rt != 5'd0) && pending[rt]) ||
                 (dec_entry.has_dest && pending[dec_entry.dest]);
  assign in_ready = !stall && !sb_full && (!out_valid_reg || out_ready);
  assign accept   = in_valid && in_ready;
  assign retire   = wb_valid && !sb_empty;
  assign wr_en    = retire && head_entry.has_dest &&
                    !(head_entry.trap_ovf && wb_flags[FLAG_OVF]);

  alu_scoreboard_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (accept),
    .push_entry (dec_entry),
    .pop        (retire),
    .head_entry (head_entry),
    .count      (sb_count),
    .full       (sb_full),
    .empty      (sb_empty),
    .pending    (pending)
  );

  assign gpr_we[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_gpr_we
      assign gpr_we[gi] = wr_en && (head_entry.dest == 5'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) gpr_reg[i] <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (gpr_we[i]) gpr_reg[i] <= wb_result;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg    <= 1'b0;
      out_instr_reg    <= '0;
      out_rega_reg     <= '0;
      out_regb_reg     <= '0;
      branch_taken_reg <= 1'b0;
      wb_err_reg       <= 1'b0;
    end else begin
      if (accept) begin
        out_valid_reg <= 1'b1;
        out_instr_reg <= in_instr;
        out_rega_reg  <= gpr_reg[rs];
        out_regb_reg  <= gpr_reg[rt];
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
      branch_taken_reg <= retire &&
                          ((head_entry.is_beq && wb_flags[FLAG_ZERO]) ||
                           (head_entry.is_bne && !wb_flags[FLAG_ZERO]));
      if (wb_valid && sb_empty) wb_err_reg <= 1'b1;
    end
  end

  assign out_valid    = out_valid_reg;
  assign out_instr    = out_instr_reg;
  assign out_regA     = out_rega_reg;
  assign out_regB     = out_regb_reg;
  assign branch_taken = branch_taken_reg;
  assign wb_err       = wb_err_reg;
  assign dbg_data     = (dbg_addr == 5'd0) ? 32'd0 : gpr_reg[dbg_addr];

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: issue, RAW stall, overflow suppression,
// branch resolve, full/backpressure and stray-writeback error.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_regA;
  logic [31:0] out_regB;
  logic        wb_valid;
  logic [31:0] wb_result;
  logic [2:0]  wb_flags;
  logic        branch_taken;
  logic        wb_err;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_operand_stage #(.DEPTH(4), .ADDR_W(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_instr     (in_instr),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_regA     (out_regA),
    .out_regB     (out_regB),
    .wb_valid     (wb_valid),
    .wb_result    (wb_result),
    .wb_flags     (wb_flags),
    .branch_taken (branch_taken),
    .wb_err       (wb_err),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s got=0x%08h", tag, got);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_gpr(input string tag, input logic [4:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    check_val(tag, dbg_data, exp);
  endtask

  task automatic retire(input logic [31:0] res, input logic [2:0] fl);
    wb_valid  = 1'b1;
    wb_result = res;
    wb_flags  = fl;
    tick();
    wb_valid  = 1'b0;
  endtask

  task automatic issue(input logic [31:0] instr);
    in_valid = 1'b1;
    in_instr = instr;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    out_ready = 1'b1;
    wb_valid  = 1'b0;
    wb_result = '0;
    wb_flags  = '0;
    dbg_addr  = '0;
    repeat (3) tick();
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_out_instr", out_instr, 32'd0);
    check_val("rst_regA", out_regA, 32'd0);
    check_val("rst_branch", 32'(branch_taken), 32'd0);
    check_val("rst_wb_err", 32'(wb_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // addiu $1,$0,5
    in_valid = 1'b1;
    in_instr = 32'h2401_0005;
    #1;
    check_val("addiu_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check_val("addiu_out_valid", 32'(out_valid), 32'd1);
    check_val("addiu_out_instr", out_instr, 32'h2401_0005);
    check_val("addiu_regA", out_regA, 32'd0);
    check_val("addiu_regB", out_regB, 32'd0);

    // addu $3,$1,$1 stalls on pending $1
    in_valid = 1'b1;
    in_instr = 32'h0021_1821;
    #1;
    check_val("raw_stall_ready", 32'(in_ready), 32'd0);
    tick();
    check_val("consumed_out_valid", 32'(out_valid), 32'd0);
    wb_valid  = 1'b1;
    wb_result = 32'd5;
    wb_flags  = 3'b000;
    #1;
    check_val("no_bypass_ready", 32'(in_ready), 32'd0);
    tick();
    wb_valid = 1'b0;
    read_gpr("gpr1_after_retire", 5'd1, 32'd5);
    check_val("raw_release_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check_val("addu_out_valid", 32'(out_valid), 32'd1);
    check_val("addu_regA", out_regA, 32'd5);
    check_val("addu_regB", out_regB, 32'd5);
    retire(32'd10, 3'b000);
    read_gpr("gpr3_addu", 5'd3, 32'h0000_000A);

    // add $3,$1,$1 with overflow: write suppressed, pending still cleared
    issue(32'h0021_1820);
    retire(32'd2, 3'b001);
    read_gpr("gpr3_ovf_suppressed", 5'd3, 32'h0000_000A);
    in_valid = 1'b1;
    in_instr = 32'h0021_1821;
    #1;
    check_val("pending3_cleared", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    retire(32'd2, 3'b001);
    read_gpr("gpr3_addu_ovf_flag", 5'd3, 32'd2);

    // Branch resolve
    issue(32'h1000_0004);
    check_val("beq_no_early_pulse", 32'(branch_taken), 32'd0);
    retire(32'd0, 3'b100);
    check_val("beq_taken_pulse", 32'(branch_taken), 32'd1);
    tick();
    check_val("beq_pulse_ends", 32'(branch_taken), 32'd0);
    issue(32'h1400_0004);
    retire(32'd0, 3'b100);
    check_val("bne_zero_not_taken", 32'(branch_taken), 32'd0);
    issue(32'h1400_0004);
    retire(32'd1, 3'b000);
    check_val("bne_taken_pulse", 32'(branch_taken), 32'd1);

    // Backpressure hold, then fill to DEPTH
    out_ready = 1'b0;
    issue(32'h2401_0001);
    in_valid = 1'b1;
    in_instr = 32'h2402_0002;
    #1;
    check_val("bp_in_ready", 32'(in_ready), 32'd0);
    tick();
    check_val("bp_hold_valid", 32'(out_valid), 32'd1);
    check_val("bp_hold_instr", out_instr, 32'h2401_0001);
    out_ready = 1'b1;
    #1;
    check_val("bp_release_ready", 32'(in_ready), 32'd1);
    tick();
    in_instr = 32'h2403_0003;
    tick();
    in_instr = 32'h2404_0004;
    tick();
    check_val("fill_last_instr", out_instr, 32'h2404_0004);
    in_instr = 32'h2405_0005;
    wb_valid  = 1'b1;
    wb_result = 32'h11;
    wb_flags  = 3'b000;
    #1;
    check_val("full_blocks_ready", 32'(in_ready), 32'd0);
    tick();
    wb_valid = 1'b0;
    #1;
    check_val("after_pop_ready", 32'(in_ready), 32'd1);
    check_val("full_no_accept_valid", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    check_val("fifth_accept_instr", out_instr, 32'h2405_0005);
    read_gpr("gpr1_full_retire", 5'd1, 32'h11);
    retire(32'h22, 3'b000);
    retire(32'h33, 3'b000);
    retire(32'h44, 3'b000);
    retire(32'h55, 3'b000);
    read_gpr("gpr4_drain", 5'd4, 32'h44);
    read_gpr("gpr5_drain", 5'd5, 32'h55);

    // Stray writeback with empty scoreboard
    retire(32'hDEAD_BEEF, 3'b000);
    check_val("stray_wb_err", 32'(wb_err), 32'd1);
    read_gpr("stray_no_gpr_write", 5'd5, 32'h55);
    tick();
    check_val("wb_err_sticky", 32'(wb_err), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_rst_wb_err", 32'(wb_err), 32'd0);
    read_gpr("rst_clears_gpr", 5'd5, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
